mnist_dense_engine: RTL and testbench

- Parametrised fully-connected layer engine for the MNIST datapath; successor to the fixed 20-neuron / 10-neuron layers.
- Accepts one input activation vector, then consumes one weight row plus bias per accepted beat, computing one neuron per cycle.
- Returns the full output vector over a valid/ready handshake.
- Cascadable: the m_* side of layer k connects to the s_* side of layer k+1.

---
 rtl/mnist_dense_engine_pkg.sv | 35 +++
 rtl/mnist_dense_engine_if.sv | 44 ++++
 rtl/mnist_dense_engine_dot_sat.sv | 49 ++++
 rtl/mnist_dense_engine.sv | 136 +++++++++++++
 tb/tb_mnist_dense_engine.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mnist_dense_engine_pkg.sv
// Shared state encoding and fixed-point helpers for the MNIST dense layers.
package mnist_nn_pkg;

    localparam int FRAC_W_DFLT = 12;
    localparam int SAT_W       = 192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Wide enough that a full dot product plus bias can never overflow.
    function automatic int acc_w(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in);
    endfunction

    function automatic int idx_w(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

    // Clamp v to the signed data_w range; MSB of the return flags a clip.
    function automatic logic [SAT_W:0] saturate(input logic signed [SAT_W-1:0] v,
                                                input int data_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) << (data_w - 1)) - SAT_W'(1);
        lo = ~hi;
        if (v > hi) return {1'b1, hi};
        if (v < lo) return {1'b1, lo};
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/mnist_dense_engine_if.sv
// Handshake bundle of one dense layer: input vector, weight-row stream and output vector.
// Carries m_class only when MNIST_DENSE_ARGMAX_EN is defined.
interface mnist_dense_engine_if #(
    parameter int N_IN   = 256,
    parameter int N_OUT  = 20,
    parameter int DATA_W = 32
);
    localparam int IDX_W = mnist_nn_pkg::idx_w(N_OUT);

    logic                     s_valid;
    logic                     s_ready;
    logic [N_IN*DATA_W-1:0]   s_data;
    logic                     w_valid;
    logic                     w_ready;
    logic [N_IN*DATA_W-1:0]   w_data;
    logic [DATA_W-1:0]        w_bias;
    logic [IDX_W-1:0]         w_idx;
    logic                     m_valid;
    logic                     m_ready;
    logic [N_OUT*DATA_W-1:0]  m_data;
    logic                     m_ovf;
    logic                     busy;
`ifdef MNIST_DENSE_ARGMAX_EN
    logic [IDX_W-1:0]         m_class;
`endif

    // master feeds vectors/rows and drains results; slave is the engine itself
    modport master (
        output s_valid, s_data, w_valid, w_data, w_bias, m_ready,
        input  s_ready, w_ready, w_idx, m_valid, m_data, m_ovf, busy
`ifdef MNIST_DENSE_ARGMAX_EN
        , input m_class
`endif
    );

    modport slave (
        input  s_valid, s_data, w_valid, w_data, w_bias, m_ready,
        output s_ready, w_ready, w_idx, m_valid, m_data, m_ovf, busy
`ifdef MNIST_DENSE_ARGMAX_EN
        , output m_class
`endif
    );

endinterface

// File: rtl/mnist_dense_engine_dot_sat.sv
// Combinational neuron: signed dot product plus bias, fixed-point rescale, saturation and
// optional ReLU, with a flag when the result had to be clipped.
module mnist_dot_sat import mnist_nn_pkg::*; #(
    parameter int N_IN   = 256,
    parameter int DATA_W = 32,
    parameter int FRAC_W = FRAC_W_DFLT,
    parameter int RELU   = 0
) (
    input  logic [N_IN*DATA_W-1:0] act_i,
    input  logic [N_IN*DATA_W-1:0] wgt_i,
    input  logic [DATA_W-1:0]      bias_i,
    output logic [DATA_W-1:0]      res_o,
    output logic                   ovf_o
);
    localparam int ACC_W = acc_w(DATA_W, N_IN);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic [SAT_W:0]          sat;
    logic                    sat_unused;

    always_comb begin
        logic signed [DATA_W-1:0]   a;
        logic signed [DATA_W-1:0]   w;
        logic signed [2*DATA_W-1:0] p;
        a   = '0;
        w   = '0;
        p   = '0;
        acc = ACC_W'($signed(bias_i)) <<< FRAC_W;
        for (int j = 0; j < N_IN; j++) begin
            a   = act_i[j*DATA_W +: DATA_W];
            w   = wgt_i[j*DATA_W +: DATA_W];
            p   = a * w;
            acc = acc + ACC_W'(p);
        end
    end

    // arithmetic shift truncates toward minus infinity
    assign acc_sh     = acc >>> FRAC_W;
    assign sat        = saturate(SAT_W'(acc_sh), DATA_W);
    assign sat_unused = ^sat[SAT_W-1:DATA_W];

    always_comb begin
        res_o = sat[DATA_W-1:0];
        ovf_o = sat[SAT_W];
        if (RELU != 0 && res_o[DATA_W-1]) res_o = '0;
    end

endmodule

// File: rtl/mnist_dense_engine.sv
// Fully-connected layer engine: latches one activation vector, then turns one weight row per
// accepted beat into one neuron. MNIST_DENSE_ARGMAX_EN adds a running argmax output (m_class).
//
// state    | meaning
// ST_IDLE  | waiting for an input vector, s_ready high
// ST_RUN   | accepting weight rows, one neuron per beat
// ST_FLUSH | last neuron result being written
// ST_DONE  | output vector valid, held until m_ready
module mnist_dense_engine import mnist_nn_pkg::*; #(
    parameter int N_IN   = 256,
    parameter int N_OUT  = 20,
    parameter int DATA_W = 32,
    parameter int FRAC_W = FRAC_W_DFLT,
    parameter int RELU   = 0
) (
    input logic                 clk,
    input logic                 rst,
    mnist_dense_engine_if.slave bus
);
    localparam int               IDX_W    = idx_w(N_OUT);
    localparam int               VEC_W    = N_IN * DATA_W;
    localparam int               OUT_W    = N_OUT * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   act_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   slot_q;
    logic               pend_q;
    logic [DATA_W-1:0]  res_q;
    logic               rovf_q;
    logic [OUT_W-1:0]   m_data_q;
    logic               m_ovf_q;
    logic               s_fire, w_fire, m_fire;
    logic [DATA_W-1:0]  dot_res;
    logic               dot_ovf;

    assign s_fire = bus.s_valid && (state_q == ST_IDLE);
    assign w_fire = bus.w_valid && (state_q == ST_RUN);
    assign m_fire = bus.m_ready && (state_q == ST_DONE);

    mnist_dot_sat #(
        .N_IN   (N_IN),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .RELU   (RELU)
    ) u_dot_sat (
        .act_i  (act_q),
        .wgt_i  (bus.w_data),
        .bias_i (bus.w_bias),
        .res_o  (dot_res),
        .ovf_o  (dot_ovf)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (s_fire) state_d = ST_RUN;
            ST_RUN:   if (w_fire && idx_q == LAST_IDX) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  if (m_fire) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (s_fire) begin
            idx_d = '0;
        end else if (w_fire) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Neuron result is staged for a cycle, then written into its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            act_q    <= '0;
            idx_q    <= '0;
            slot_q   <= '0;
            pend_q   <= 1'b0;
            res_q    <= '0;
            rovf_q   <= 1'b0;
            m_data_q <= '0;
            m_ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= w_fire;
            if (s_fire) act_q <= bus.s_data;
            if (w_fire) begin
                res_q  <= dot_res;
                rovf_q <= dot_ovf;
                slot_q <= idx_q;
            end
            if (s_fire) begin
                m_ovf_q <= 1'b0;
            end else if (pend_q && rovf_q) begin
                m_ovf_q <= 1'b1;
            end
            for (int j = 0; j < N_OUT; j++) begin
                if (pend_q && slot_q == IDX_W'(j)) m_data_q[j*DATA_W +: DATA_W] <= res_q;
            end
        end
    end

`ifdef MNIST_DENSE_ARGMAX_EN
    logic signed [DATA_W-1:0] max_q;
    logic [IDX_W-1:0]         cls_q;

    // Strict compare on ascending slot order keeps the lowest index on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            cls_q <= '0;
        end else if (pend_q) begin
            if (slot_q == '0 || $signed(res_q) > max_q) begin
                max_q <= res_q;
                cls_q <= slot_q;
            end
        end
    end

    assign bus.m_class = cls_q;
`endif

    assign bus.s_ready = (state_q == ST_IDLE);
    assign bus.w_ready = (state_q == ST_RUN);
    assign bus.w_idx   = idx_q;
    assign bus.m_valid = (state_q == ST_DONE);
    assign bus.m_data  = m_data_q;
    assign bus.m_ovf   = m_ovf_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mnist_dense_engine.sv
// Directed bench for mnist_dense_engine: a linear and a ReLU instance share one stimulus stream.
module tb_mnist_dense_engine;
    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int DATA_W = 32;
    localparam int FRAC_W = 12;
    localparam int VEC_W  = N_IN * DATA_W;
    localparam int OUT_W  = N_OUT * DATA_W;
    localparam int IDX_W  = 2;
    localparam logic [OUT_W-1:0] BASIC_EXP = {32'h0000_1000, 32'h0000_2000, 32'h0000_2400};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [VEC_W-1:0]  act_v;
    logic [VEC_W-1:0]  row_v  [N_OUT];
    logic [DATA_W-1:0] bias_v [N_OUT];

    int                lat;
    int                unstable;
    logic [OUT_W-1:0]  d, dr;
    logic              ovf, ovfr;
    logic [IDX_W-1:0]  cls;

    mnist_dense_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W)) bus ();
    mnist_dense_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W)) bus_r ();

    assign bus_r.s_valid = bus.s_valid;
    assign bus_r.s_data  = bus.s_data;
    assign bus_r.w_valid = bus.w_valid;
    assign bus_r.w_data  = bus.w_data;
    assign bus_r.w_bias  = bus.w_bias;
    assign bus_r.m_ready = bus.m_ready;

    mnist_dense_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .RELU(0))
        u_dut (.clk(clk), .rst(rst), .bus(bus));
    mnist_dense_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W), .FRAC_W(FRAC_W), .RELU(1))
        u_dut_relu (.clk(clk), .rst(rst), .bus(bus_r));

    always #5 clk = ~clk;

    task automatic load(input logic [31:0] a, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] b0, input logic [31:0] b1,
                        input logic [31:0] b2);
        act_v     = {N_IN{a}};
        row_v[0]  = {N_IN{r0}};
        row_v[1]  = {N_IN{r1}};
        row_v[2]  = {N_IN{r2}};
        bias_v[0] = b0;
        bias_v[1] = b1;
        bias_v[2] = b2;
    endtask

    // One full vector: s handshake, rows (optional gap after row 0), m_ready held off mr_hold
    // cycles. lat counts clock edges from the s handshake edge (inclusive) to m_valid; -1 on timeout.
    task automatic run_vec(input int gap_len, input int mr_hold);
        int   n, beat, gap_left, mv_cnt;
        logic wfire;
        bit   fin;
        n = 0; beat = 0; gap_left = 0; mv_cnt = 0; fin = 0;
        lat = -1; unstable = 0; d = '0; dr = '0; ovf = 1'b0; ovfr = 1'b0; cls = '0;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = act_v;
        bus.w_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        n = 1;
        while (!fin && n < 60) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            if (bus.m_valid === 1'b1) begin
                if (mv_cnt == 0) begin
                    lat  = n;
                    d    = bus.m_data;
                    ovf  = bus.m_ovf;
                    dr   = bus_r.m_data;
                    ovfr = bus_r.m_ovf;
`ifdef MNIST_DENSE_ARGMAX_EN
                    cls  = bus.m_class;
`endif
                end else if (bus.m_data !== d || bus.m_ovf !== ovf) begin
                    unstable++;
                end
                mv_cnt++;
            end
            bus.m_ready = (bus.m_valid === 1'b1) && (mv_cnt > mr_hold);
            fin = bus.m_ready;
            if (gap_left > 0) begin
                bus.w_valid = 1'b0;
                gap_left--;
            end else if (beat < N_OUT) begin
                bus.w_valid = 1'b1;
                bus.w_data  = row_v[beat];
                bus.w_bias  = bias_v[beat];
            end else begin
                bus.w_valid = 1'b0;
            end
            wfire = bus.w_valid && (bus.w_ready === 1'b1);
            @(posedge clk);
            n++;
            if (wfire) begin
                beat++;
                if (beat == 1) gap_left = gap_len;
            end
        end
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.w_valid = 1'b0;
        if (!fin) lat = -1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.s_ready, bus.w_ready, bus.m_valid, bus.busy, bus.m_ovf} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 10000",
                     {bus.s_ready, bus.w_ready, bus.m_valid, bus.busy, bus.m_ovf});
        end
        checks++;
        if (bus.w_idx !== 2'd0 || bus.m_data !== '0) begin
            failures++;
            $display("FAIL reset_data: w_idx %0d m_data %h want 0", bus.w_idx, bus.m_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: s_ready %b busy %b want 1 0", bus.s_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        load(32'h1000, 32'h0800, 32'h0800, 32'h0800, 32'h400, 32'h0, 32'hFFFF_F000);
        run_vec(0, 0);
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 5", lat);
        end
        checks++;
        if (d !== BASIC_EXP || ovf !== 1'b0) begin
            failures++;
            $display("FAIL basic_data: got %h ovf %b want %h ovf 0", d, ovf, BASIC_EXP);
        end
        checks++;
        if (dr !== BASIC_EXP) begin
            failures++;
            $display("FAIL basic_relu_data: got %h want %h", dr, BASIC_EXP);
        end
    endtask

    task automatic test_stall();
        load(32'h1000, 32'h0800, 32'h0800, 32'h0800, 32'h400, 32'h0, 32'hFFFF_F000);
        run_vec(3, 4);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL stall_latency: got %0d want 8", lat);
        end
        checks++;
        if (d !== BASIC_EXP) begin
            failures++;
            $display("FAIL stall_data: got %h want %h", d, BASIC_EXP);
        end
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL stall_hold: got %0d changes while held want 0", unstable);
        end
    endtask

    task automatic test_saturation();
        load(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0);
        run_vec(0, 0);
        checks++;
        if (d !== {N_OUT{32'h7FFF_FFFF}} || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos: got %h ovf %b want %h ovf 1", d, ovf, {N_OUT{32'h7FFF_FFFF}});
        end
        load(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
        run_vec(0, 0);
        checks++;
        if (d !== {N_OUT{32'h8000_0000}} || ovf !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg: got %h ovf %b want %h ovf 1", d, ovf, {N_OUT{32'h8000_0000}});
        end
        checks++;
        if (dr !== '0 || ovfr !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg_relu: got %h ovf %b want 0 ovf 1", dr, ovfr);
        end
    endtask

    task automatic test_relu();
        load(32'h1000, 32'h0800, 32'hFFFF_F000, 32'h0800, 32'h400, 32'h0, 32'hFFFF_F000);
        run_vec(0, 0);
        checks++;
        if (dr !== {32'h1000, 32'h0, 32'h2400} || ovfr !== 1'b0) begin
            failures++;
            $display("FAIL relu_data: got %h ovf %b want %h ovf 0", dr, ovfr,
                     {32'h1000, 32'h0, 32'h2400});
        end
        checks++;
        if (d !== {32'h1000, 32'hFFFF_C000, 32'h2400} || ovf !== 1'b0) begin
            failures++;
            $display("FAIL relu_linear_ref: got %h ovf %b want %h ovf 0", d, ovf,
                     {32'h1000, 32'hFFFF_C000, 32'h2400});
        end
    endtask

    task automatic test_rounding();
        load(32'h1, 32'hFFFF_FFFF, 32'h1, 32'h3FF, 32'h0, 32'h0, 32'h1);
        run_vec(0, 0);
        checks++;
        if (d !== {32'h1, 32'h0, 32'hFFFF_FFFF}) begin
            failures++;
            $display("FAIL round_floor: got %h want %h", d, {32'h1, 32'h0, 32'hFFFF_FFFF});
        end
        checks++;
        if (dr !== {32'h1, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL round_relu: got %h want %h", dr, {32'h1, 32'h0, 32'h0});
        end
    endtask

    task automatic test_reset_mid_run();
        load(32'h1000, 32'h0800, 32'h0800, 32'h0800, 32'h400, 32'h0, 32'hFFFF_F000);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = act_v;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.w_valid = 1'b1;
            bus.w_data  = row_v[i];
            bus.w_bias  = bias_v[i];
            @(posedge clk);
        end
        @(negedge clk);
        bus.w_valid = 1'b0;
        checks++;
        if (bus.w_idx !== 2'd2 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_progress: w_idx %0d busy %b want 2 1", bus.w_idx, bus.busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.s_ready, bus.w_ready, bus.m_valid, bus.busy, bus.m_ovf} !== 5'b10000 ||
            bus.w_idx !== 2'd0 || bus.m_data !== '0) begin
            failures++;
            $display("FAIL midrun_reset: flags %b w_idx %0d m_data %h want 10000 0 0",
                     {bus.s_ready, bus.w_ready, bus.m_valid, bus.busy, bus.m_ovf},
                     bus.w_idx, bus.m_data);
        end
        @(negedge clk);
        rst = 1'b0;
        run_vec(0, 0);
        checks++;
        if (lat !== 5 || d !== BASIC_EXP) begin
            failures++;
            $display("FAIL midrun_fresh: latency %0d data %h want 5 %h", lat, d, BASIC_EXP);
        end
    endtask

    task automatic test_argmax();
`ifdef MNIST_DENSE_ARGMAX_EN
        load(32'h1000, 32'h0800, 32'h0800, 32'h0800, 32'h400, 32'h400, 32'hFFFF_F000);
        run_vec(0, 0);
        checks++;
        if (d !== {32'h1000, 32'h2400, 32'h2400} || cls !== 2'd0) begin
            failures++;
            $display("FAIL argmax_tie: data %h class %0d want %h 0", d, cls,
                     {32'h1000, 32'h2400, 32'h2400});
        end
        load(32'h1000, 32'h0800, 32'h0800, 32'h0800, 32'h400, 32'h400, 32'h1000);
        run_vec(0, 0);
        checks++;
        if (d !== {32'h3000, 32'h2400, 32'h2400} || cls !== 2'd2) begin
            failures++;
            $display("FAIL argmax_top: data %h class %0d want %h 2", d, cls,
                     {32'h3000, 32'h2400, 32'h2400});
        end
`endif
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.w_bias  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_saturation();
        test_relu();
        test_rounding();
        test_reset_mid_run();
        test_argmax();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
